// File: rtl/bu2020_fetch.sv
`timescale 1ns/1ps
// bu2020_fetch: instruction fetch unit for the BU2020 core.
// Owns the fetch PC, issues one outstanding word read at a time and buffers
// returned instructions in a small prefetch queue drained by execute through
// a valid/ready handshake. A redirect from execute flushes all stale state.
module bu2020_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned PC_STEP  = 4,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc
);

  localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam logic [15:0] STEP_C  = 16'(PC_STEP);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] ZERO_C  = CW'(0);
  localparam logic [PW-1:0] PONE_C  = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        state_r;
  logic [15:0]   fetch_pc_r;
  logic [15:0]   q_instr_r [DEPTH];
  logic [15:0]   q_pc_r    [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          mem_req_r;
  logic [15:0]   mem_addr_r;
  logic          instr_valid_r;

  logic          push_s;
  logic          pop_s;
  logic [CW-1:0] count_next_s;
  logic [15:0]   pc_inc_s;

  // Queue bookkeeping: a redirect flushes and overrides any push or pop.
  always_comb begin
    push_s       = 1'b0;
    pop_s        = 1'b0;
    count_next_s = count_r;
    pc_inc_s     = fetch_pc_r + STEP_C;
    if (redirect_valid) begin
      push_s       = 1'b0;
      pop_s        = 1'b0;
      count_next_s = ZERO_C;
    end else begin
      push_s = (state_r == S_WAIT) && mem_ack;
      pop_s  = (count_r != ZERO_C) && instr_ready;
      if (push_s && !pop_s) begin
        count_next_s = count_r + ONE_C;
      end else if (pop_s && !push_s) begin
        count_next_s = count_r - ONE_C;
      end else begin
        count_next_s = count_r;
      end
    end
  end

  // Prefetch queue storage: written only on an accepted memory response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_instr_r[i] <= 16'h0000;
        q_pc_r[i]    <= 16'h0000;
      end
    end else if (push_s) begin
      q_instr_r[wr_ptr_r] <= mem_rdata;
      q_pc_r[wr_ptr_r]    <= mem_addr_r;
    end
  end

  // Queue pointers, occupancy and the registered head-valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r      <= {PW{1'b0}};
      wr_ptr_r      <= {PW{1'b0}};
      count_r       <= ZERO_C;
      instr_valid_r <= 1'b0;
    end else begin
      count_r       <= count_next_s;
      instr_valid_r <= (count_next_s != ZERO_C);
      if (redirect_valid) begin
        wr_ptr_r <= rd_ptr_r;
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + PONE_C;
        if (pop_s)  rd_ptr_r <= rd_ptr_r + PONE_C;
      end
    end
  end

  // Fetch FSM: owns the fetch PC and the registered memory request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      fetch_pc_r <= RESET_PC;
      mem_req_r  <= 1'b0;
      mem_addr_r <= 16'h0000;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (redirect_valid) begin
            fetch_pc_r <= redirect_pc;
            mem_addr_r <= redirect_pc;
            mem_req_r  <= 1'b1;
            state_r    <= S_WAIT;
          end else if (count_r < DEPTH_C) begin
            mem_addr_r <= fetch_pc_r;
            mem_req_r  <= 1'b1;
            state_r    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            if (redirect_valid) begin
              // Returned word belongs to the old stream: drop it, restart.
              fetch_pc_r <= redirect_pc;
              mem_addr_r <= redirect_pc;
              mem_req_r  <= 1'b1;
              state_r    <= S_WAIT;
            end else begin
              fetch_pc_r <= pc_inc_s;
              mem_addr_r <= pc_inc_s;
              if (count_next_s < DEPTH_C) begin
                mem_req_r <= 1'b1;
                state_r   <= S_WAIT;
              end else begin
                mem_req_r <= 1'b0;
                state_r   <= S_IDLE;
              end
            end
          end else if (redirect_valid) begin
            // Old request must still complete; hold it and discard later.
            fetch_pc_r <= redirect_pc;
            state_r    <= S_DROP;
          end
        end
        S_DROP: begin
          if (mem_ack) begin
            fetch_pc_r <= redirect_valid ? redirect_pc : fetch_pc_r;
            mem_addr_r <= redirect_valid ? redirect_pc : fetch_pc_r;
            mem_req_r  <= 1'b1;
            state_r    <= S_WAIT;
          end else if (redirect_valid) begin
            fetch_pc_r <= redirect_pc;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req     = mem_req_r;
  assign mem_addr    = mem_addr_r;
  assign instr_valid = instr_valid_r;
  assign instr       = q_instr_r[rd_ptr_r];
  assign instr_pc    = q_pc_r[rd_ptr_r];

endmodule

// File: doc/bu2020_fetch.md
# bu2020_fetch

Instruction fetch unit for the BU2020 core, sitting directly upstream of the execute stage. It owns the fetch program counter, issues single-outstanding word reads to instruction memory, and buffers returned instructions in a 2-entry prefetch queue. Execute consumes instructions through a valid/ready handshake. On taken branches (`BNE`) and jumps (`J`), execute redirects the fetch PC, and this block flushes all stale state.

## Interface
- `RESET_PC`, 16'h0000, fetch address after reset
- `PC_STEP`, 4, fetch PC increment per instruction (matches execute's PC+4)
- `DEPTH`, 2, prefetch queue entries (power of two, ≥2)

Ports:
- `clk` in 1: single clock; all state on rising edge
- `rst_n` in 1: reset, asynchronous and active-low
- `mem_req` out 1: read request outstanding (registered)
- `mem_addr` out 16: request address, stable while `mem_req`=1 (registered)
- `mem_ack` in 1: completes current request; `mem_rdata` valid this cycle
- `mem_rdata` in 16: instruction word
- `instr_valid` out 1: queue head valid
- `instr` out 16: queue head instruction
- `instr_pc` out 16: address the head instruction was fetched from
- `instr_ready` in 1: execute accepts head this cycle
- `redirect_valid` in 1: one-cycle pulse, replace fetch PC
- `redirect_pc` in 16: new fetch PC

## Operation
- State: `fetch_pc` (16b), queue (`DEPTH` × {instr, pc}), `count`, FSM {IDLE, WAIT, DROP}.
- IDLE: if `count` < `DEPTH` and no redirect, go to WAIT with `mem_req`=1 and `mem_addr`=`fetch_pc`.
- WAIT: hold `mem_req`/`mem_addr` until `mem_ack`. On ack:
  - push {`mem_rdata`, `mem_addr`} into the queue.
  - `fetch_pc` += `PC_STEP`.
  - If `count` after push/pop < `DEPTH`, stay in WAIT with `mem_addr` set to the new `fetch_pc` (back-to-back request). Otherwise go to IDLE with `mem_req`=0.
- Outstanding requests never exceed 1. A slot is reserved before issue, so a push never overflows.
- Pop: on `instr_valid` && `instr_ready`. Push and pop in the same cycle leave `count` unchanged.
- `instr_valid` = (`count` != 0). `instr`/`instr_pc` show the queue head.
- Redirect (`redirect_valid`=1) has priority over everything:
  - queue flushed (`count`=0); any same-cycle pop is ignored.
  - `fetch_pc` = `redirect_pc`.
  - If WAIT without ack: go to DROP, keeping `mem_req`/`mem_addr` at the old request.
  - If WAIT with ack this cycle: discard the data and go to WAIT at `redirect_pc`.
  - If IDLE: go to WAIT at `redirect_pc`.
- DROP: hold the old request until `mem_ack`, discard the data, then go to WAIT with `mem_addr`=`fetch_pc`. A redirect during DROP updates `fetch_pc` and stays in DROP.
- Arithmetic: `fetch_pc` is 16b and wraps modulo 2^16 (0xFFFC + 4 → 0x0000). No fault is raised.
- Reset values:
  - `mem_req`=0, `mem_addr`=0x0000
  - `instr_valid`=0, `instr`=0x0000, `instr_pc`=0x0000
  - `fetch_pc`=`RESET_PC`, `count`=0, FSM=IDLE
- Reset asserted mid-request returns to IDLE immediately and abandons the request. Memory must drop any pending ack across reset.

## Timing
- Cycle 0 is the first rising edge after `rst_n` deasserts. `mem_req`=1 from the edge after cycle 0.
- Minimum memory latency is 1: `mem_ack` may be high in the first cycle after `mem_req` rises. An ack while `mem_req`=0 is illegal.
- Fetch-to-execute latency: `instr_valid` rises on the edge that samples `mem_ack` (1 cycle after ack presented).
- Steady-state throughput with ack latency 1 and `instr_ready`=1 is 1 instruction per cycle.
- Redirect-to-`instr_valid`=0 takes 1 cycle. The first redirected instruction appears ≥2 cycles after redirect in IDLE/WAIT, plus the remaining ack latency if in DROP.
- `mem_addr` changes only on the edge that samples `mem_ack`, on issue from IDLE, or on reset.

## Test plan
- Straight-line fetch: reset, memory returns `0xC201`, `0xC402`, `0xC603` with ack latency 1, `instr_ready`=1 → instructions delivered in order, `instr_pc`=0x0000/0x0004/0x0008, no bubbles after the first.
- Backpressure: `instr_ready`=0 for 10 cycles → exactly 2 entries fetched, `mem_req`=0 with `mem_addr`=0x0008 not yet issued. Then `instr_ready`=1 → head 0x0000 popped and request 0x0008 issues the next cycle.
- Redirect in flight: in WAIT at 0x0004 with ack latency 3, pulse redirect to 0x0100 → queue empty next cycle, ack data for 0x0004 discarded, next `mem_addr`=0x0100, first delivered `instr_pc`=0x0100.
- Redirect coincident with ack and pop: same cycle `mem_ack`, `instr_ready`, `redirect_pc`=0x0040 → no stale instruction ever valid, next request is 0x0040.
- Wrap: redirect to 0xFFFC → `instr_pc` sequence 0xFFFC, 0x0000.
- Reset mid-operation: drop `rst_n` during WAIT with 1 queued entry → `mem_req`/`instr_valid` low asynchronously. After release, fetch restarts at `RESET_PC`.
